dose_scheduler: RTL and testbench

Dose scheduler for the prescription reminder. It scans the pill-schedule ROM once per clock second and matches each entry's due time against the running BCD time of day. It queues every due dose, presents one reminder at a time with a grace countdown, and logs each unacknowledged dose into the missed-dose RAM. It sits between the Clock, ROM, RAM and shaped take-button, and drives the LCD/LED reminder indicators.

---
 rtl/prescription_pkg.sv | 27 ++
 rtl/schedule_scanner.sv | 98 +++++++++
 rtl/dose_scheduler.sv | 131 +++++++++++++
 tb/tb_dose_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prescription_pkg.sv
// Shared definitions for the prescription reminder: ROM entry fields,
// FSM state encodings and the missed-dose log record.
package prescription_pkg;

  localparam int PILL_MSB = 27;
  localparam int PILL_LSB = 24;
  localparam int TIME_MSB = 23;

  localparam logic [3:0] EMPTY_PILL = 4'd0;

  typedef enum logic {
    SCAN_IDLE,
    SCANNING
  } scan_state_t;

  typedef enum logic [1:0] {
    ALERT_IDLE,
    ALERTING,
    LOG_MISS
  } alert_state_t;

  typedef struct packed {
    logic [3:0]  pill;
    logic [23:0] stamp;
  } miss_rec_t;

endpackage

// File: rtl/schedule_scanner.sv
// Walks the schedule ROM once per second and raises pending[k] for slots due now.
//   SCAN_IDLE | waiting for a second tick; ROM address parked at 0
//   SCANNING  | issuing addresses and comparing returned entries
module schedule_scanner #(
  parameter  int NUM_ENTRIES = 8,
  localparam int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_second_tick,
  input  logic [23:0]                 i_current_time,
  output logic [7:0]                  o_rom_address,
  input  logic [27:0]                 i_rom_data,
  input  logic                        i_clr_valid,
  input  logic [IDX_W-1:0]            i_clr_idx,
  output logic [NUM_ENTRIES-1:0]      o_pending,
  output logic [NUM_ENTRIES-1:0][3:0] o_pills
);
  import prescription_pkg::*;

  scan_state_t r_state, w_state_nxt;
  logic [IDX_W-1:0]            r_addr, r_cmp_idx;
  logic                        r_addr_vld, r_cmp_vld;
  logic [23:0]                 r_time;
  logic [NUM_ENTRIES-1:0]      r_pending;
  logic [NUM_ENTRIES-1:0][3:0] r_pills;
  logic                        w_start, w_match;
  logic [3:0]                  w_rom_pill;
  logic [23:0]                 w_rom_time;

  assign w_rom_pill = i_rom_data[PILL_MSB:PILL_LSB];
  assign w_rom_time = i_rom_data[TIME_MSB:0];
  assign w_start    = (r_state == SCAN_IDLE) && i_second_tick && i_enable;
  assign w_match    = r_cmp_vld && (w_rom_pill != EMPTY_PILL) && (w_rom_time == r_time);

  assign o_rom_address = 8'(r_addr);
  assign o_pending     = r_pending;
  assign o_pills       = r_pills;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= SCAN_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SCAN_IDLE: if (w_start) w_state_nxt = SCANNING;
      SCANNING:  if (!r_addr_vld && !r_cmp_vld) w_state_nxt = SCAN_IDLE;
      default:   w_state_nxt = SCAN_IDLE;
    endcase
  end

  // Address stage feeds a compare stage one cycle later, matching ROM latency.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr     <= '0;
      r_addr_vld <= 1'b0;
      r_cmp_idx  <= '0;
      r_cmp_vld  <= 1'b0;
      r_time     <= '0;
    end else begin
      r_cmp_vld <= r_addr_vld;
      r_cmp_idx <= r_addr;
      if (w_start) begin
        r_addr     <= '0;
        r_addr_vld <= 1'b1;
        r_time     <= i_current_time;
      end else if (r_addr_vld) begin
        if (r_addr == IDX_W'(NUM_ENTRIES - 1)) begin
          r_addr     <= '0;
          r_addr_vld <= 1'b0;
        end else begin
          r_addr <= r_addr + IDX_W'(1);
        end
      end
    end
  end

  // A clear of the alerted slot wins over a coincident re-match of it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pending <= '0;
      r_pills   <= '0;
    end else begin
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        if (i_clr_valid && (i_clr_idx == IDX_W'(k))) begin
          r_pending[k] <= 1'b0;
        end else if (w_match && (r_cmp_idx == IDX_W'(k)) && !r_pending[k]) begin
          r_pending[k] <= 1'b1;
          r_pills[k]   <= w_rom_pill;
        end
      end
    end
  end

endmodule

// File: rtl/dose_scheduler.sv
// Presents due doses one at a time with a grace countdown and logs missed ones.
//   ALERT_IDLE | no reminder shown; picks the lowest pending slot
//   ALERTING   | reminder shown, grace counting down on second ticks
//   LOG_MISS   | one-cycle missed-dose RAM write
module dose_scheduler #(
  parameter int NUM_ENTRIES   = 8,
  parameter int GRACE_SECONDS = 30,
  parameter int LOG_DEPTH     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        secondTick,
  input  logic [23:0] currentTime,
  input  logic        takeButton,
  output logic [7:0]  romAddress,
  input  logic [27:0] romData,
  output logic [7:0]  ramAddress,
  output logic [27:0] ramData,
  output logic        ramWren,
  output logic        reminderActive,
  output logic [3:0]  reminderPill,
  output logic [11:0] graceRemaining,
  output logic        takenPulse,
  output logic [7:0]  missCount
);
  import prescription_pkg::*;

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  alert_state_t r_state, w_state_nxt;
  logic [NUM_ENTRIES-1:0]      w_pending;
  logic [NUM_ENTRIES-1:0][3:0] w_pills;
  logic [IDX_W-1:0]            r_sel, w_low_idx;
  logic [3:0]                  r_pill;
  logic [11:0]                 r_grace;
  logic [23:0]                 r_miss_time;
  logic [7:0]                  r_log_ptr, r_miss_count;
  logic                        r_taken;
  logic                        w_tick, w_expire, w_take, w_clr, w_active;
  miss_rec_t                   w_rec;

  schedule_scanner #(.NUM_ENTRIES(NUM_ENTRIES)) u_scanner (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_enable       (enable),
    .i_second_tick  (secondTick),
    .i_current_time (currentTime),
    .o_rom_address  (romAddress),
    .i_rom_data     (romData),
    .i_clr_valid    (w_clr),
    .i_clr_idx      (r_sel),
    .o_pending      (w_pending),
    .o_pills        (w_pills)
  );

  assign w_tick   = secondTick && enable;
  assign w_take   = (r_state == ALERTING) && takeButton;
  assign w_expire = (r_state == ALERTING) && !takeButton && w_tick && (r_grace == 12'd1);
  assign w_clr    = w_take || (r_state == LOG_MISS);
  assign w_active = (r_state != ALERT_IDLE);

  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_pending[i]) w_low_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ALERT_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ALERT_IDLE: if (|w_pending) w_state_nxt = ALERTING;
      ALERTING: begin
        if (takeButton)    w_state_nxt = ALERT_IDLE;
        else if (w_expire) w_state_nxt = LOG_MISS;
      end
      LOG_MISS: w_state_nxt = ALERT_IDLE;
      default:  w_state_nxt = ALERT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel        <= '0;
      r_pill       <= '0;
      r_grace      <= '0;
      r_miss_time  <= '0;
      r_log_ptr    <= '0;
      r_miss_count <= '0;
      r_taken      <= 1'b0;
    end else begin
      r_taken <= w_take;
      case (r_state)
        ALERT_IDLE: begin
          if (|w_pending) begin
            r_sel   <= w_low_idx;
            r_pill  <= w_pills[w_low_idx];
            r_grace <= 12'(GRACE_SECONDS);
          end
        end
        ALERTING: begin
          if (!takeButton && w_tick) r_grace <= r_grace - 12'd1;
          if (w_expire) r_miss_time <= currentTime;
        end
        LOG_MISS: begin
          r_log_ptr <= (r_log_ptr == 8'(LOG_DEPTH - 1)) ? 8'd0 : r_log_ptr + 8'd1;
          if (r_miss_count != 8'hFF) r_miss_count <= r_miss_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_rec = '{pill: r_pill, stamp: r_miss_time};

  assign reminderActive = w_active;
  assign reminderPill   = w_active ? r_pill : 4'd0;
  assign graceRemaining = w_active ? r_grace : 12'd0;
  assign takenPulse     = r_taken;
  assign missCount      = r_miss_count;
  assign ramWren        = (r_state == LOG_MISS);
  assign ramAddress     = (r_state == LOG_MISS) ? r_log_ptr : 8'd0;
  assign ramData        = (r_state == LOG_MISS) ? w_rec : 28'd0;

endmodule

// File: tb/tb_dose_scheduler.sv
// Directed bench for dose_scheduler with a 3-second grace and a 4-deep log.
module tb_dose_scheduler;
  localparam int N     = 8;
  localparam int GRACE = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, enable, secondTick, takeButton;
  logic [23:0] currentTime;
  logic [7:0]  romAddress, ramAddress, missCount;
  logic [27:0] romData, ramData;
  logic        ramWren, reminderActive, takenPulse;
  logic [3:0]  reminderPill;
  logic [11:0] graceRemaining;

  logic [27:0] rom [0:255];
  int n_vec    = 0;
  int n_bad    = 0;
  int n_writes = 0;

  dose_scheduler #(
    .NUM_ENTRIES   (N),
    .GRACE_SECONDS (GRACE),
    .LOG_DEPTH     (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .secondTick     (secondTick),
    .currentTime    (currentTime),
    .takeButton     (takeButton),
    .romAddress     (romAddress),
    .romData        (romData),
    .ramAddress     (ramAddress),
    .ramData        (ramData),
    .ramWren        (ramWren),
    .reminderActive (reminderActive),
    .reminderPill   (reminderPill),
    .graceRemaining (graceRemaining),
    .takenPulse     (takenPulse),
    .missCount      (missCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) romData <= rom[romAddress];
  always @(posedge clk) if (ramWren === 1'b1) n_writes <= n_writes + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic tick(input logic [23:0] t);
    currentTime = t;
    secondTick  = 1'b1;
    step();
    secondTick  = 1'b0;
  endtask

  task automatic take();
    takeButton = 1'b1;
    step();
    takeButton = 1'b0;
  endtask

  task automatic wait_active(input string tag);
    int k = 0;
    while (reminderActive !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    chk(tag, reminderActive, 1);
  endtask

  task automatic miss_cycle(input logic [23:0] base, input logic [3:0] pill,
                            input logic [7:0] addr, input logic [7:0] cnt);
    logic [27:0] exp_d;
    exp_d = {pill, base + 24'h000003};
    tick(base);
    wait_active("miss_alert");
    chk("miss_pill", reminderPill, pill);
    chk("miss_grace3", graceRemaining, GRACE);
    idle(12);
    tick(base + 24'h000001);
    chk("miss_grace2", graceRemaining, 2);
    idle(12);
    tick(base + 24'h000002);
    chk("miss_grace1", graceRemaining, 1);
    idle(12);
    tick(base + 24'h000003);
    chk("miss_wren", ramWren, 1);
    chk("miss_addr", ramAddress, addr);
    chk("miss_data", ramData, exp_d);
    chk("miss_grace0", graceRemaining, 0);
    chk("miss_active_e1", reminderActive, 1);
    step();
    chk("miss_active_e2", reminderActive, 0);
    chk("miss_wren_off", ramWren, 0);
    chk("miss_count", missCount, cnt);
    idle(12);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_active"}, reminderActive, 0);
    chk({tag, "_pill"}, reminderPill, 0);
    chk({tag, "_grace"}, graceRemaining, 0);
    chk({tag, "_taken"}, takenPulse, 0);
    chk({tag, "_miss"}, missCount, 0);
    chk({tag, "_wren"}, ramWren, 0);
    chk({tag, "_raddr"}, ramAddress, 0);
    chk({tag, "_rdata"}, ramData, 0);
    chk({tag, "_romaddr"}, romAddress, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 28'd0;
    rom[1] = {4'd5, 24'h120000};
    rom[2] = {4'd3, 24'h080000};
    rom[5] = {4'd7, 24'h120000};
    rom[6] = {4'd9, 24'h090000};

    reset       = 1'b1;
    enable      = 1'b1;
    secondTick  = 1'b0;
    takeButton  = 1'b0;
    currentTime = 24'h0;
    idle(3);
    chk_all_zero("reset");
    reset = 1'b0;
    idle(2);

    // single due slot, acknowledged
    tick(24'h080000);
    chk("scan_addr0", romAddress, 0);
    step();
    chk("scan_addr1", romAddress, 1);
    step();
    chk("scan_addr2", romAddress, 2);
    idle(2);
    chk("alert_t5", reminderActive, 0);
    step();
    chk("alert_t6", reminderActive, 1);
    chk("alert_pill", reminderPill, 3);
    chk("alert_grace", graceRemaining, GRACE);
    idle(8);
    chk("scan_parked", romAddress, 0);
    take();
    chk("take_pulse", takenPulse, 1);
    chk("take_active", reminderActive, 0);
    chk("take_pill", reminderPill, 0);
    step();
    chk("take_pulse_off", takenPulse, 0);
    chk("take_no_write", n_writes, 0);
    take();
    chk("take_idle_ignored", takenPulse, 0);
    idle(4);

    // expiry writes the log
    miss_cycle(24'h080000, 4'd3, 8'd0, 8'd1);

    // two slots due together, served in ascending order
    tick(24'h120000);
    idle(3);
    chk("multi_t4", reminderActive, 0);
    step();
    chk("multi_first_active", reminderActive, 1);
    chk("multi_first_pill", reminderPill, 5);
    idle(8);
    chk("multi_first_held", reminderPill, 5);
    take();
    chk("multi_take_pulse", takenPulse, 1);
    chk("multi_take_gap", reminderActive, 0);
    step();
    chk("multi_second_active", reminderActive, 1);
    chk("multi_second_pill", reminderPill, 7);
    chk("multi_second_grace", graceRemaining, GRACE);
    take();
    step();
    chk("multi_drained", reminderActive, 0);
    idle(10);

    // take coincides with the expiring tick
    tick(24'h080000);
    wait_active("race_alert");
    idle(12);
    tick(24'h080001);
    idle(12);
    tick(24'h080002);
    chk("race_grace1", graceRemaining, 1);
    idle(12);
    currentTime = 24'h080003;
    secondTick  = 1'b1;
    takeButton  = 1'b1;
    step();
    secondTick  = 1'b0;
    takeButton  = 1'b0;
    chk("race_taken", takenPulse, 1);
    chk("race_wren", ramWren, 0);
    chk("race_active", reminderActive, 0);
    step();
    chk("race_miss_count", missCount, 1);
    chk("race_writes", n_writes, 1);
    idle(12);

    // log pointer wraps after DEPTH entries
    for (int m = 0; m < 4; m++) begin
      miss_cycle(24'h090000, 4'd9, 8'((m + 1) % DEPTH), 8'(m + 2));
    end
    chk("wrap_writes", n_writes, 5);

    // reset mid-alert, then the empty slot at midnight
    tick(24'h080000);
    wait_active("rst_alert");
    idle(2);
    reset = 1'b1;
    step();
    chk_all_zero("rst_mid");
    reset = 1'b0;
    idle(15);
    chk("rst_pending_cleared", reminderActive, 0);
    tick(24'h000000);
    idle(15);
    chk("empty_slot", reminderActive, 0);
    chk("rst_no_write", n_writes, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
